// File: rtl/fifo_drain_ctrl_if.sv
// fifo_drain_ctrl_if: FIFO read port plus downstream valid/ready stream of the drain controller
interface fifo_drain_ctrl_if #(parameter int DATA_W = 32) ();
  logic              fifo_rd_enb;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  modport master (
    output fifo_rd_enb, m_data, m_valid,
    input  fifo_empty, fifo_data, m_ready
  );
  modport slave (
    input  fifo_rd_enb, m_data, m_valid,
    output fifo_empty, fifo_data, m_ready
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: drains an 8-deep FIFO into a valid/ready stream via a 2-entry skid buffer
module fifo_drain_ctrl #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LEN_W-1:0]    burst_len,
  input  logic                stop,
  fifo_drain_ctrl_if.master   bus,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    word_cnt
);
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;
  state_t            state, state_n;
  logic [LEN_W-1:0]  remaining;
  logic              cont;
  logic              inflight;
  logic [1:0]        occ;
  logic [1:0]        occ_sh;
  logic [2:0]        pend;
  logic [DATA_W-1:0] buf0, buf1;
  logic              pop;
  logic              issue;
  // pend counts words the buffer must still hold next cycle; a new read is only safe below 2
  always_comb begin
    pop     = (occ != 2'd0) & bus.m_ready;
    occ_sh  = occ - {1'b0, pop};
    pend    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    issue   = (state == DRAIN) & !stop & !bus.fifo_empty & (cont | (remaining != '0)) & (pend < 3'd2);
    state_n = state == IDLE  ? (start ? DRAIN : IDLE) :
              state == DRAIN ? ((stop | (!cont & (remaining == '0))) ? FLUSH : DRAIN) :
              state == FLUSH ? ((!inflight & (occ == 2'd0)) ? DONE : FLUSH) :
                               IDLE;
  end
  assign bus.fifo_rd_enb = issue;
  assign bus.m_valid     = occ != 2'd0;
  assign bus.m_data      = buf0;
  assign busy            = (state == DRAIN) | (state == FLUSH);
  assign done            = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      cont      <= 1'b0;
      inflight  <= 1'b0;
      occ       <= 2'd0;
      buf0      <= '0;
      buf1      <= '0;
      word_cnt  <= '0;
    end else begin
      state    <= state_n;
      inflight <= issue;
      occ      <= occ_sh + {1'b0, inflight};
      if (pop) buf0 <= buf1;
      if (inflight && occ_sh == 2'd0) buf0 <= bus.fifo_data;
      if (inflight && occ_sh != 2'd0) buf1 <= bus.fifo_data;
      if (state == IDLE && start) begin
        word_cnt  <= '0;
        remaining <= burst_len;
        cont      <= burst_len == '0;
      end else begin
        if (issue && !cont) remaining <= remaining - 1'b1;
        if (pop) word_cnt <= word_cnt + 1'b1;
      end
    end
  end
endmodule
